// File: rtl/shape_edge_sequencer.sv
// Edge sequencer: turns one packed draw command into a backpressured stream of {start,end} edge beats.
// Optional build macro SHAPE_SEQ_DEGEN_SKIP_EN drops zero-length LINE/TRI/QUAD edges from the stream.
module shape_edge_sequencer #(
    parameter int COLOR_W  = 16,
    parameter int X_W      = 10,
    parameter int Y_W      = 9,
    parameter int MAX_VERT = 4
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [COLOR_W+MAX_VERT*(X_W+Y_W)+1-1:0]   cmd_data,
    input  logic [1:0]                                cmd_shape,
    input  logic                                      cmd_valid,
    output logic                                      cmd_ready,
    output logic [2*(X_W+Y_W)-1:0]                    out_loc,
    output logic [COLOR_W-1:0]                        out_color,
    output logic                                      out_fill,
    output logic [1:0]                                out_edge,
    output logic                                      out_last,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic                                      cmd_done,
    output logic                                      cmd_err
);

    localparam int PT_W  = X_W + Y_W;
    localparam int CMD_W = COLOR_W + MAX_VERT*PT_W + 1;

`ifdef SHAPE_SEQ_DEGEN_SKIP_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EMIT = 1'b1;

    localparam logic [1:0] SH_LINE = 2'd0;
    localparam logic [1:0] SH_TRI  = 2'd1;
    localparam logic [1:0] SH_CIRC = 2'd2;
    localparam logic [1:0] SH_QUAD = 2'd3;

    logic [0:0]          state;
    logic [1:0]          shape_q;
    logic [1:0]          edge_idx;
    logic                last_q;
    logic [PT_W-1:0]     pt_in  [4];
    logic [PT_W-1:0]     pt_q   [4];
    logic [PT_W-1:0]     src_pt [4];
    logic [1:0]          src_shape;
    logic [1:0]          ld_idx;
    logic [1:0]          s_idx  [4];
    logic [1:0]          e_idx  [4];
    logic [2:0]          n_edges;
    logic [3:0]          degen;
    logic                ld_degen;
    logic                ld_last;
    logic [2*PT_W-1:0]   ld_loc;
    logic                illegal;
    logic                accept;
    logic                advance;
    logic                retire;
    logic                do_load;

    // Unpack points from the command word; slots beyond MAX_VERT read as zero.
    for (genvar i = 0; i < 4; i++) begin : g_pt
        if (i < MAX_VERT) begin : g_used
            assign pt_in[i] = cmd_data[1 + (MAX_VERT-1-i)*PT_W +: PT_W];
        end else begin : g_pad
            assign pt_in[i] = '0;
        end
    end

    assign cmd_ready = (state == IDLE);

    // The first beat is built straight from the incoming command so it is ready one cycle after acceptance.
    always_comb begin
        src_shape = (state == IDLE) ? cmd_shape : shape_q;
        for (int i = 0; i < 4; i++) begin
            src_pt[i] = (state == IDLE) ? pt_in[i] : pt_q[i];
        end
        ld_idx = (state == IDLE) ? 2'd0 : edge_idx + 2'd1;
    end

    always_comb begin
        for (int e = 0; e < 4; e++) begin
            s_idx[e] = 2'd0;
            e_idx[e] = 2'd1;
        end
        n_edges = 3'd1;
        case (src_shape)
            SH_TRI: begin
                n_edges  = 3'd3;
                s_idx[1] = 2'd0; e_idx[1] = 2'd2;
                s_idx[2] = 2'd1; e_idx[2] = 2'd2;
            end
            SH_QUAD: begin
                n_edges  = 3'd4;
                s_idx[1] = 2'd1; e_idx[1] = 2'd2;
                s_idx[2] = 2'd2; e_idx[2] = 2'd3;
                s_idx[3] = 2'd3; e_idx[3] = 2'd0;
            end
            default: n_edges = 3'd1;
        endcase

        for (int e = 0; e < 4; e++) begin
            degen[e] = SKIP_EN && (src_shape != SH_CIRC) && (3'(e) < n_edges) &&
                       (src_pt[s_idx[e]] == src_pt[e_idx[e]]);
        end

        // Last emitted beat: no non-degenerate edge remains after the one being loaded.
        ld_last = 1'b1;
        for (int e = 0; e < 4; e++) begin
            if ((3'(e) > {1'b0, ld_idx}) && (3'(e) < n_edges) && !degen[e]) begin
                ld_last = 1'b0;
            end
        end

        ld_degen = degen[ld_idx];
        ld_loc   = {src_pt[s_idx[ld_idx]], src_pt[e_idx[ld_idx]]};
        illegal  = (src_shape == SH_QUAD) && (MAX_VERT < 4);
    end

    assign accept  = (state == IDLE) && cmd_valid;
    assign advance = (state == EMIT) && (out_ready || !out_valid);
    assign retire  = advance && last_q;
    assign do_load = (accept && !illegal) || (advance && !last_q);

    // A skipped edge occupies one cycle with out_valid low and then advances without a handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shape_q   <= SH_LINE;
            edge_idx  <= 2'd0;
            last_q    <= 1'b0;
            out_loc   <= '0;
            out_color <= '0;
            out_fill  <= 1'b0;
            out_edge  <= 2'd0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
            cmd_done  <= 1'b0;
            cmd_err   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                pt_q[i] <= '0;
            end
        end else begin
            cmd_done <= retire || (accept && illegal);
            cmd_err  <= accept && illegal;

            if (accept && !illegal) begin
                state     <= EMIT;
                shape_q   <= cmd_shape;
                out_color <= cmd_data[CMD_W-1 -: COLOR_W];
                out_fill  <= cmd_data[0];
                for (int i = 0; i < 4; i++) begin
                    pt_q[i] <= pt_in[i];
                end
            end

            if (do_load) begin
                edge_idx  <= ld_idx;
                out_edge  <= ld_idx;
                out_loc   <= ld_loc;
                out_valid <= !ld_degen;
                out_last  <= ld_last && !ld_degen;
                last_q    <= ld_last;
            end else if (retire) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                last_q    <= 1'b0;
                state     <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_shape_edge_sequencer.sv
// Directed testbench for shape_edge_sequencer; expected degenerate-edge behaviour follows SHAPE_SEQ_DEGEN_SKIP_EN.
module tb_shape_edge_sequencer;

    localparam int COLOR_W  = 16;
    localparam int X_W      = 10;
    localparam int Y_W      = 9;
    localparam int MAX_VERT = 4;
    localparam int PT_W     = X_W + Y_W;
    localparam int CMD_W    = COLOR_W + MAX_VERT*PT_W + 1;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [CMD_W-1:0]    cmd_data = '0;
    logic [1:0]          cmd_shape = 2'd0;
    logic                cmd_valid = 1'b0;
    logic                cmd_ready;
    logic [2*PT_W-1:0]   out_loc;
    logic [COLOR_W-1:0]  out_color;
    logic                out_fill;
    logic [1:0]          out_edge;
    logic                out_last;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic                cmd_done;
    logic                cmd_err;

    int errors = 0;
    int checks = 0;

    shape_edge_sequencer #(
        .COLOR_W(COLOR_W), .X_W(X_W), .Y_W(Y_W), .MAX_VERT(MAX_VERT)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_data(cmd_data), .cmd_shape(cmd_shape), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .out_loc(out_loc), .out_color(out_color), .out_fill(out_fill), .out_edge(out_edge),
        .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
        .cmd_done(cmd_done), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    function automatic logic [PT_W-1:0] mk_pt(input int x, input int y);
        return {X_W'(x), Y_W'(y)};
    endfunction

    function automatic logic [CMD_W-1:0] mk_cmd(input logic [COLOR_W-1:0] color,
                                                input logic [PT_W-1:0] p0, input logic [PT_W-1:0] p1,
                                                input logic [PT_W-1:0] p2, input logic [PT_W-1:0] p3,
                                                input logic fill);
        return {color, p0, p1, p2, p3, fill};
    endfunction

    // Returns at the negedge just after acceptance; command inputs are then scrambled.
    task automatic send_cmd(input logic [1:0] shape, input logic [CMD_W-1:0] data);
        int waited = 0;
        @(negedge clk);
        while (!cmd_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL send_ready: cmd_ready=%0b, required 1 within 20 cycles", cmd_ready);
        end
        cmd_shape = shape;
        cmd_data  = data;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_data  = {CMD_W{1'b1}};
        cmd_shape = 2'd1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({out_valid, out_last, cmd_done, cmd_err, out_fill, out_edge} !== 7'd0 ||
            out_loc !== '0 || out_color !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: valid=%0b last=%0b done=%0b err=%0b loc=%h color=%h fill=%0b edge=%0d, required all 0",
                     out_valid, out_last, cmd_done, cmd_err, out_loc, out_color, out_fill, out_edge);
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_ready: cmd_ready=%0b, required 1", cmd_ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_line();
        logic [PT_W-1:0] p0, p1;
        p0 = mk_pt(10, 20);
        p1 = mk_pt(300, 200);
        out_ready = 1'b1;
        send_cmd(2'd0, mk_cmd(16'h07E0, p0, p1, '0, '0, 1'b0));
        checks++;
        if ({out_valid, out_edge, out_last} !== {1'b1, 2'd0, 1'b1} || out_loc !== {p0, p1}) begin
            errors++;
            $display("[TB] FAIL line_beat: valid=%0b edge=%0d last=%0b loc=%h, required 1/0/1 loc=%h",
                     out_valid, out_edge, out_last, out_loc, {p0, p1});
        end
        checks++;
        if (out_color !== 16'h07E0 || out_fill !== 1'b0) begin
            errors++;
            $display("[TB] FAIL line_attr: color=%h fill=%0b, required 07e0/0", out_color, out_fill);
        end
        @(negedge clk);
        checks++;
        if ({out_valid, cmd_done, cmd_ready} !== 3'b011) begin
            errors++;
            $display("[TB] FAIL line_done: valid=%0b done=%0b ready=%0b, required 0/1/1",
                     out_valid, cmd_done, cmd_ready);
        end
    endtask

    task automatic test_tri();
        logic [PT_W-1:0]   p0, p1, p2;
        logic [2*PT_W-1:0] exp_loc [3];
        int n;
        bit done;
        p0 = mk_pt(0, 0);
        p1 = mk_pt(5, 0);
        p2 = mk_pt(0, 5);
        exp_loc[0] = {p0, p1};
        exp_loc[1] = {p0, p2};
        exp_loc[2] = {p1, p2};
        out_ready = 1'b1;
        send_cmd(2'd1, mk_cmd(16'h001F, p0, p1, p2, '0, 1'b0));
        n = 0;
        done = 0;
        for (int c = 0; c < 12 && !done; c++) begin
            if (cmd_done) begin
                done = 1;
            end else if (out_valid) begin
                checks++;
                if (n >= 3 || out_loc !== exp_loc[n] || out_edge !== 2'(n) || out_last !== (n == 2)) begin
                    errors++;
                    $display("[TB] FAIL tri_beat%0d: loc=%h edge=%0d last=%0b, required loc=%h edge=%0d last=%0b",
                             n, out_loc, out_edge, out_last, exp_loc[n % 3], n, (n == 2));
                end
                n++;
            end
            if (!done) @(negedge clk);
        end
        checks++;
        if (!done || n != 3) begin
            errors++;
            $display("[TB] FAIL tri_count: beats=%0d done=%0b, required 3/1", n, done);
        end
    endtask

    task automatic test_quad_stall();
        logic [PT_W-1:0]   p [4];
        logic [2*PT_W-1:0] exp_loc [4];
        logic [2*PT_W-1:0] prev_loc;
        logic [1:0]        prev_edge;
        bit stalled, done;
        int k;
        p[0] = mk_pt(1, 1);
        p[1] = mk_pt(8, 1);
        p[2] = mk_pt(8, 8);
        p[3] = mk_pt(1, 8);
        for (int i = 0; i < 4; i++) exp_loc[i] = {p[i], p[(i + 1) % 4]};
        out_ready = 1'b0;
        send_cmd(2'd3, mk_cmd(16'h1234, p[0], p[1], p[2], p[3], 1'b1));
        k = 0;
        stalled = 0;
        done = 0;
        prev_loc = '0;
        prev_edge = 2'd0;
        for (int c = 0; c < 30 && !done; c++) begin
            if (cmd_done) begin
                done = 1;
            end else begin
                if (stalled) begin
                    checks++;
                    if (out_valid !== 1'b1 || out_loc !== prev_loc || out_edge !== prev_edge) begin
                        errors++;
                        $display("[TB] FAIL quad_hold: valid=%0b loc=%h edge=%0d, required 1 loc=%h edge=%0d",
                                 out_valid, out_loc, out_edge, prev_loc, prev_edge);
                    end
                end else if (out_valid) begin
                    checks++;
                    if (k >= 4 || out_loc !== exp_loc[k % 4] || out_edge !== 2'(k) || out_last !== (k == 3)) begin
                        errors++;
                        $display("[TB] FAIL quad_beat%0d: loc=%h edge=%0d last=%0b, required loc=%h edge=%0d last=%0b",
                                 k, out_loc, out_edge, out_last, exp_loc[k % 4], k, (k == 3));
                    end
                end
                out_ready = c[0];
                if (out_valid && out_ready) k++;
                stalled   = out_valid && !out_ready;
                prev_loc  = out_loc;
                prev_edge = out_edge;
                @(negedge clk);
            end
        end
        checks++;
        if (!done || k != 4 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL quad_count: beats=%0d done=%0b valid=%0b, required 4/1/0", k, done, out_valid);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_circ();
        logic [PT_W-1:0] ctr, rad;
        ctr = mk_pt(320, 240);
        rad = mk_pt(50, 0);
        out_ready = 1'b1;
        send_cmd(2'd2, mk_cmd(16'hF800, ctr, rad, '0, '0, 1'b1));
        checks++;
        if ({out_valid, out_edge, out_last} !== {1'b1, 2'd0, 1'b1} || out_loc !== {ctr, rad}) begin
            errors++;
            $display("[TB] FAIL circ_beat: valid=%0b edge=%0d last=%0b loc=%h, required 1/0/1 loc=%h",
                     out_valid, out_edge, out_last, out_loc, {ctr, rad});
        end
        checks++;
        if (out_color !== 16'hF800 || out_fill !== 1'b1) begin
            errors++;
            $display("[TB] FAIL circ_attr: color=%h fill=%0b, required f800/1", out_color, out_fill);
        end
        @(negedge clk);
        checks++;
        if ({out_valid, cmd_done} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL circ_done: valid=%0b done=%0b, required 0/1", out_valid, cmd_done);
        end
    endtask

    task automatic test_reset_mid_cmd();
        logic [PT_W-1:0] q0, q1, q2, q3, l0, l1;
        q0 = mk_pt(2, 2);  q1 = mk_pt(9, 2);
        q2 = mk_pt(9, 9);  q3 = mk_pt(2, 9);
        l0 = mk_pt(1, 2);  l1 = mk_pt(3, 4);
        out_ready = 1'b1;
        send_cmd(2'd3, mk_cmd(16'hABCD, q0, q1, q2, q3, 1'b1));
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_edge !== 2'd1 || out_loc !== {q1, q2}) begin
            errors++;
            $display("[TB] FAIL rstmid_beat2: valid=%0b edge=%0d loc=%h, required 1/1 loc=%h",
                     out_valid, out_edge, out_loc, {q1, q2});
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, out_last, cmd_done, cmd_err, out_fill, out_edge} !== 7'd0 ||
            out_loc !== '0 || out_color !== '0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rstmid_clear: valid=%0b last=%0b done=%0b loc=%h color=%h ready=%0b, required zeros and ready=1",
                     out_valid, out_last, cmd_done, out_loc, out_color, cmd_ready);
        end
        @(negedge clk);
        checks++;
        if (cmd_done !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rstmid_nodone: done=%0b valid=%0b, required 0/0", cmd_done, out_valid);
        end
        rst = 1'b0;
        send_cmd(2'd0, mk_cmd(16'h0F0F, l0, l1, '0, '0, 1'b0));
        checks++;
        if ({out_valid, out_edge, out_last} !== {1'b1, 2'd0, 1'b1} || out_loc !== {l0, l1} ||
            out_color !== 16'h0F0F) begin
            errors++;
            $display("[TB] FAIL rstmid_line: valid=%0b edge=%0d last=%0b loc=%h color=%h, required 1/0/1 loc=%h color=0f0f",
                     out_valid, out_edge, out_last, out_loc, out_color, {l0, l1});
        end
        @(negedge clk);
        checks++;
        if ({out_valid, cmd_done} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL rstmid_done: valid=%0b done=%0b, required 0/1", out_valid, cmd_done);
        end
    endtask

    task automatic test_degen_tri();
        logic [PT_W-1:0]   p0, p1, p2;
        logic [2*PT_W-1:0] exp_loc  [3];
        logic [1:0]        exp_edge [3];
        int exp_n, n;
        bit done;
        p0 = mk_pt(7, 7);
        p1 = mk_pt(7, 7);
        p2 = mk_pt(20, 3);
`ifdef SHAPE_SEQ_DEGEN_SKIP_EN
        exp_n = 2;
        exp_loc[0] = {p0, p2};  exp_edge[0] = 2'd1;
        exp_loc[1] = {p1, p2};  exp_edge[1] = 2'd2;
        exp_loc[2] = '0;        exp_edge[2] = 2'd0;
`else
        exp_n = 3;
        exp_loc[0] = {p0, p1};  exp_edge[0] = 2'd0;
        exp_loc[1] = {p0, p2};  exp_edge[1] = 2'd1;
        exp_loc[2] = {p1, p2};  exp_edge[2] = 2'd2;
`endif
        out_ready = 1'b1;
        send_cmd(2'd1, mk_cmd(16'h5555, p0, p1, p2, '0, 1'b0));
        n = 0;
        done = 0;
        for (int c = 0; c < 12 && !done; c++) begin
            if (cmd_done) begin
                done = 1;
            end else if (out_valid) begin
                checks++;
                if (n >= exp_n || out_loc !== exp_loc[n % 3] || out_edge !== exp_edge[n % 3] ||
                    out_last !== (n == exp_n - 1)) begin
                    errors++;
                    $display("[TB] FAIL degen_beat%0d: loc=%h edge=%0d last=%0b, required loc=%h edge=%0d last=%0b",
                             n, out_loc, out_edge, out_last, exp_loc[n % 3], exp_edge[n % 3], (n == exp_n - 1));
                end
                n++;
            end
            if (!done) @(negedge clk);
        end
        checks++;
        if (!done || n != exp_n) begin
            errors++;
            $display("[TB] FAIL degen_count: beats=%0d done=%0b, required %0d/1", n, done, exp_n);
        end
    endtask

    initial begin
        $display("[TB] shape_edge_sequencer directed tests");
        test_reset();
        test_line();
        test_tri();
        test_quad_stall();
        test_circ();
        test_reset_mid_cmd();
        test_degen_tri();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
